// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter with a one-hot registered grant, a dead TURN slot
// between owners and a hold-time limit that forcibly ends long ownership.
module bus_grant_arbiter #(
   parameter int N_SRC    = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [N_SRC-1:0] req,
   // "release" is a reserved word, so the owner-done strobe is named release_bus.
   input  logic             release_bus,
   output logic [N_SRC-1:0] grant,
   output logic             grant_valid,
   output logic             timeout,
   output logic [1:0]       dbg_state
);

   localparam int IDX_W = $clog2(N_SRC);
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_SRC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [7:0]       hold_cnt_q, hold_cnt_d;
   logic [N_SRC-1:0] grant_q, grant_d;
   logic             grant_valid_q, grant_valid_d;
   logic             timeout_q, timeout_d;

   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [N_SRC-1:0] win_onehot;
   int               cand;

   logic             owner_req;
   logic             hold_limit;
   logic             grant_end;

   // Scan ptr+1, ptr+2, ... with wrap; the first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= N_SRC) begin
            cand = cand - N_SRC;
         end
         if (!win_found && req[IDX_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
   end

   assign owner_req  = req[ptr_q];
   assign hold_limit = (hold_cnt_q == HOLD_LAST);
   assign grant_end  = release_bus | ~owner_req | hold_limit;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      grant_d    = grant_q;
      timeout_d  = 1'b0;

      case (state_q)
         IDLE, TURN: begin
            grant_d    = '0;
            hold_cnt_d = '0;
            if (win_found) begin
               state_d = GRANT;
               grant_d = win_onehot;
               ptr_d   = win_idx;
            end else begin
               state_d = IDLE;
            end
         end

         GRANT: begin
            if (grant_end) begin
               state_d    = TURN;
               grant_d    = '0;
               hold_cnt_d = '0;
               // A release or dropped request coinciding with the limit is a normal end.
               timeout_d  = hold_limit & ~release_bus & owner_req;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            hold_cnt_d = '0;
         end
      endcase

      grant_valid_d = |grant_d;
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q       <= IDLE;
         ptr_q         <= PTR_RESET;
         hold_cnt_q    <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         hold_cnt_q    <= hold_cnt_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign timeout     = timeout_q;
   assign dbg_state   = state_q;

endmodule
